reg_holder_bank: RTL

- Responder datapath for the layer-1/layer-2 controller's register-holder command interface.
- Holds the 10 layer-1 neuron sums (16-bit each) in a 10-entry register file.
- Captures all 10 entries in parallel from the MAC array. Returns entries one at a time to the activation LUT, and writes activated values back per address.
- Streams entries to the layer-2 multiplier, with registered outputs, valid strobes and status flags.

---
 rtl/reg_holder_bank.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reg_holder_bank.sv
// rtl/reg_holder_bank.sv - register-holder responder: 10-entry neuron-sum file with LUT and multiplier read ports

module reg_holder_bank #(
  parameter int DATA_W      = 16,
  parameter int NUM_ENTRIES = 10,
  parameter int ADDR_W      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          reg_holder_in,
  input  logic                          reg_holder_mux_in,
  input  logic                          reg_holder_out,
  input  logic                          reg_holder_mux_out,
  input  logic [ADDR_W-1:0]             reg_holder_addr,
  input  logic [DATA_W*NUM_ENTRIES-1:0] mac_data,
  input  logic [DATA_W-1:0]             lut_data_in,
  input  logic                          err_clear,
  output logic [DATA_W-1:0]             lut_data_out,
  output logic                          lut_out_valid,
  output logic [DATA_W-1:0]             mult_data,
  output logic                          mult_valid,
  output logic [NUM_ENTRIES-1:0]        entry_valid,
  output logic                          act_done,
  output logic                          addr_err,
  output logic                          rd_invalid
);

  logic [DATA_W-1:0]      entries_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      entries_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] entry_valid_q, entry_valid_d;
  logic [NUM_ENTRIES-1:0] activated_q, activated_d;
  logic [DATA_W-1:0]      lut_data_out_q, lut_data_out_d;
  logic                   lut_out_valid_q, lut_out_valid_d;
  logic [DATA_W-1:0]      mult_data_q, mult_data_d;
  logic                   mult_valid_q, mult_valid_d;
  logic                   act_done_q, act_done_d;
  logic                   addr_err_q, addr_err_d;
  logic                   rd_invalid_q, rd_invalid_d;

  logic                   addr_ok;
  logic                   mac_load;
  logic                   lut_write;
  logic                   rd_ok;
  logic [DATA_W-1:0]      rd_entry;
  logic                   rd_entry_valid;
  logic                   addr_evt;
  logic                   rd_inv_evt;

  // Decode commands and select the addressed entry from the pre-write contents
  always_comb begin
    addr_ok        = int'(reg_holder_addr) < NUM_ENTRIES;
    mac_load       = reg_holder_in && !reg_holder_mux_in;
    lut_write      = reg_holder_in && reg_holder_mux_in && addr_ok;
    rd_ok          = reg_holder_out && addr_ok;
    rd_entry       = '0;
    rd_entry_valid = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (reg_holder_addr == ADDR_W'(i)) begin
        rd_entry       = entries_q[i];
        rd_entry_valid = entry_valid_q[i];
      end
    end
    addr_evt   = (reg_holder_in && reg_holder_mux_in && !addr_ok) ||
                 (reg_holder_out && !addr_ok);
    rd_inv_evt = rd_ok && !rd_entry_valid;
  end

  // Next-state for the register file, output registers and flags
  always_comb begin
    entries_d     = entries_q;
    entry_valid_d = entry_valid_q;
    activated_d   = activated_q;
    if (mac_load) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_d[i] = mac_data[DATA_W*i +: DATA_W];
      end
      entry_valid_d = '1;
      activated_d   = '0;
    end else if (lut_write) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (reg_holder_addr == ADDR_W'(i)) begin
          entries_d[i]     = lut_data_in;
          activated_d[i]   = 1'b1;
          entry_valid_d[i] = 1'b1;
        end
      end
    end

    lut_data_out_d  = lut_data_out_q;
    lut_out_valid_d = rd_ok && !reg_holder_mux_out;
    if (lut_out_valid_d) lut_data_out_d = rd_entry;

    mult_data_d  = mult_data_q;
    mult_valid_d = rd_ok && reg_holder_mux_out;
    if (mult_valid_d) mult_data_d = rd_entry;

    // Act-done tracks the updated activated vector so a MAL load drops it on the same edge
    act_done_d   = &activated_d;
    // Error flags are sticky; a new event in the clearing cycle wins
    addr_err_d   = addr_evt || (addr_err_q && !err_clear);
    rd_invalid_d = rd_inv_evt || (rd_invalid_q && !err_clear);
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= '0;
      entry_valid_q   <= '0;
      activated_q     <= '0;
      lut_data_out_q  <= '0;
      lut_out_valid_q <= 1'b0;
      mult_data_q     <= '0;
      mult_valid_q    <= 1'b0;
      act_done_q      <= 1'b0;
      addr_err_q      <= 1'b0;
      rd_invalid_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= entries_d[i];
      entry_valid_q   <= entry_valid_d;
      activated_q     <= activated_d;
      lut_data_out_q  <= lut_data_out_d;
      lut_out_valid_q <= lut_out_valid_d;
      mult_data_q     <= mult_data_d;
      mult_valid_q    <= mult_valid_d;
      act_done_q      <= act_done_d;
      addr_err_q      <= addr_err_d;
      rd_invalid_q    <= rd_invalid_d;
    end
  end

  assign lut_data_out  = lut_data_out_q;
  assign lut_out_valid = lut_out_valid_q;
  assign mult_data     = mult_data_q;
  assign mult_valid    = mult_valid_q;
  assign entry_valid   = entry_valid_q;
  assign act_done      = act_done_q;
  assign addr_err      = addr_err_q;
  assign rd_invalid    = rd_invalid_q;

endmodule
